// File: rtl/key_conditioner.sv
// Push-button front end: two-flop sync, per-key debounce, press/release pulses and a step-enable tick.
// Define KEY_AUTOREPEAT_EN to make a held key re-pulse key_press after REPEAT_DELAY, then every REPEAT_PERIOD.
module key_conditioner #(
    parameter int unsigned NUM_KEYS        = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 250000,
    parameter int unsigned TICK_DIV        = 4194304,
    parameter int unsigned REPEAT_DELAY    = 25000000,
    parameter int unsigned REPEAT_PERIOD   = 5000000
) (
    input  logic                CLOCK_50,
    input  logic                reset,
    input  logic [NUM_KEYS-1:0] KEY,
    output logic [NUM_KEYS-1:0] key_level,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release,
    output logic                tick
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned TW = $clog2(TICK_DIV);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [TW-1:0] TC_LAST  = TW'(TICK_DIV - 1);

    if (DEBOUNCE_CYCLES < 1 || TICK_DIV < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_param_check
        $error("key_conditioner: illegal parameter value");
    end

    logic [NUM_KEYS-1:0] sync1_q, sync2_q;
    logic [NUM_KEYS-1:0] sync_pressed;
    logic [NUM_KEYS-1:0] level_q, level_d;
    logic [NUM_KEYS-1:0] press_q, press_d;
    logic [NUM_KEYS-1:0] release_q, release_d;
    logic [NUM_KEYS-1:0] accept;
    logic [NUM_KEYS-1:0] rep_fire;
    logic [CW-1:0]       cnt_q [NUM_KEYS];
    logic [CW-1:0]       cnt_d [NUM_KEYS];
    logic [TW-1:0]       tc_q, tc_d;
    logic                tick_q, tick_d;

    assign sync_pressed = ~sync2_q;

    always_comb begin
        level_d = level_q;
        accept  = '0;
        for (int unsigned i = 0; i < NUM_KEYS; i++) begin
            cnt_d[i] = '0;
            if (sync_pressed[i] != level_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    level_d[i] = sync_pressed[i];
                    accept[i]  = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
            end
        end
        press_d   = (accept & sync_pressed) | rep_fire;
        release_d = accept & ~sync_pressed;
    end

`ifdef KEY_AUTOREPEAT_EN
    localparam int unsigned RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned RW   = $clog2(RMAX + 1);
    localparam logic [RW-1:0] RD_LAST = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] RP_LAST = RW'(REPEAT_PERIOD - 1);

    logic [RW-1:0]       rcnt_q [NUM_KEYS];
    logic [RW-1:0]       rcnt_d [NUM_KEYS];
    logic [NUM_KEYS-1:0] rphase_q, rphase_d;

    // Repeat timing restarts on every accepted level change, so a release edge never also fires a repeat.
    always_comb begin
        rep_fire = '0;
        rphase_d = '0;
        for (int unsigned i = 0; i < NUM_KEYS; i++) begin
            rcnt_d[i] = '0;
            if (level_q[i] && !accept[i]) begin
                rphase_d[i] = rphase_q[i];
                if (rcnt_q[i] == (rphase_q[i] ? RP_LAST : RD_LAST)) begin
                    rep_fire[i] = 1'b1;
                    rphase_d[i] = 1'b1;
                end else begin
                    rcnt_d[i] = rcnt_q[i] + RW'(1);
                end
            end
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            rphase_q <= '0;
            for (int unsigned i = 0; i < NUM_KEYS; i++) rcnt_q[i] <= '0;
        end else begin
            rphase_q <= rphase_d;
            for (int unsigned i = 0; i < NUM_KEYS; i++) rcnt_q[i] <= rcnt_d[i];
        end
    end
`else
    assign rep_fire = '0;
`endif

    always_comb begin
        tick_d = (tc_q == TC_LAST);
        tc_d   = tick_d ? '0 : tc_q + TW'(1);
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            sync1_q   <= '1;
            sync2_q   <= '1;
            level_q   <= '0;
            press_q   <= '0;
            release_q <= '0;
            tc_q      <= '0;
            tick_q    <= 1'b0;
            for (int unsigned i = 0; i < NUM_KEYS; i++) cnt_q[i] <= '0;
        end else begin
            sync1_q   <= KEY;
            sync2_q   <= sync1_q;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            tc_q      <= tc_d;
            tick_q    <= tick_d;
            for (int unsigned i = 0; i < NUM_KEYS; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    assign key_level   = level_q;
    assign key_press   = press_q;
    assign key_release = release_q;
    assign tick        = tick_q;

endmodule

// File: tb/tb_key_conditioner.sv
// Scoreboard bench for key_conditioner: stimulus queues expected pulse events, a negedge monitor checks them.
module tb_key_conditioner;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] KEY;
    logic [3:0] key_level, key_press, key_release;
    logic       tick;

    key_conditioner #(
        .NUM_KEYS       (4),
        .DEBOUNCE_CYCLES(4),
        .TICK_DIV       (8),
        .REPEAT_DELAY   (10),
        .REPEAT_PERIOD  (3)
    ) dut (
        .CLOCK_50   (clk),
        .reset      (reset),
        .KEY        (KEY),
        .key_level  (key_level),
        .key_press  (key_press),
        .key_release(key_release),
        .tick       (tick)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned cyc;
        logic [3:0]  press;
        logic [3:0]  rel;
        logic [3:0]  level;
    } ev_t;

    ev_t         q[$];
    ev_t         e;
    int unsigned cyc      = 0;
    int unsigned last_rst = 0;
    int unsigned n_vec    = 0;
    int unsigned n_fail   = 0;
    logic [3:0]  exp_lvl  = '0;
    logic        exp_tick;
    bit          done     = 1'b0;

    // Edge counter; last_rst marks the latest edge that sampled reset high.
    always @(posedge clk) begin
        cyc++;
        if (reset) last_rst = cyc;
    end

    always @(negedge clk) begin
        if (cyc > 0 && !done) begin
            if (cyc == last_rst) begin
                n_vec++;
                exp_lvl = '0;
                if ({key_level, key_press, key_release, tick} !== 13'd0) begin
                    n_fail++;
                    $display("FAIL reset_state cyc=%0d got lvl=%b prs=%b rel=%b tick=%b expected all 0",
                             cyc, key_level, key_press, key_release, tick);
                end
            end else begin
                exp_tick = ((cyc - last_rst) % 8) == 0;
                n_vec++;
                if (tick !== exp_tick) begin
                    n_fail++;
                    $display("FAIL tick cyc=%0d got %b expected %b", cyc, tick, exp_tick);
                end
                if ((key_press | key_release) != 4'd0 || (q.size() > 0 && q[0].cyc <= cyc)) begin
                    n_vec++;
                    if (q.size() == 0) begin
                        n_fail++;
                        $display("FAIL unexpected_pulse cyc=%0d got prs=%b rel=%b expected none",
                                 cyc, key_press, key_release);
                    end else begin
                        e = q.pop_front();
                        exp_lvl = e.level;
                        if (e.cyc != cyc || key_press !== e.press || key_release !== e.rel) begin
                            n_fail++;
                            $display("FAIL pulse_event cyc=%0d got prs=%b rel=%b expected cyc=%0d prs=%b rel=%b",
                                     cyc, key_press, key_release, e.cyc, e.press, e.rel);
                        end
                    end
                end
                n_vec++;
                if (key_level !== exp_lvl) begin
                    n_fail++;
                    $display("FAIL level cyc=%0d got %b expected %b", cyc, key_level, exp_lvl);
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // KEY driven now is first sampled at edge cyc+1, so the accepted change lands at edge cyc+6.
    task automatic expect_ev(input int unsigned at, input logic [3:0] p, input logic [3:0] r,
                             input logic [3:0] l);
        ev_t x;
        x.cyc = at; x.press = p; x.rel = r; x.level = l;
        q.push_back(x);
    endtask

    initial begin
        int unsigned acc;
        reset = 1'b1;
        KEY   = 4'b1111;
        step(3);
        reset = 1'b0;
        step(26);

        // single press and release of KEY[3]
        KEY[3] = 1'b0;
        expect_ev(cyc + 6, 4'b1000, 4'b0000, 4'b1000);
        step(10);
        KEY[3] = 1'b1;
        expect_ev(cyc + 6, 4'b0000, 4'b1000, 4'b0000);
        step(10);

        // short glitch, then chatter
        KEY[2] = 1'b0;
        step(3);
        KEY[2] = 1'b1;
        step(10);
        for (int i = 0; i < 20; i++) begin
            KEY[2] = ~KEY[2];
            step(2);
        end
        step(10);

        // simultaneous press and release of KEY[3:2]
        KEY[3:2] = 2'b00;
        expect_ev(cyc + 6, 4'b1100, 4'b0000, 4'b1100);
        step(10);
        KEY[3:2] = 2'b11;
        expect_ev(cyc + 6, 4'b0000, 4'b1100, 4'b0000);
        step(10);

        // reset inside the debounce window, key held throughout
        KEY[1] = 1'b0;
        step(3);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        expect_ev(cyc + 6, 4'b0010, 4'b0000, 4'b0010);
        step(12);
        KEY[1] = 1'b1;
        expect_ev(cyc + 6, 4'b0000, 4'b0010, 4'b0000);
        step(10);

        // held KEY[0]: auto-repeat when enabled
        KEY[0] = 1'b0;
        acc = cyc + 6;
        expect_ev(acc, 4'b0001, 4'b0000, 4'b0001);
`ifdef KEY_AUTOREPEAT_EN
        for (int k = 0; k < 7; k++) expect_ev(acc + 10 + 3 * k, 4'b0001, 4'b0000, 4'b0001);
`endif
        step(6 + 24);
        KEY[0] = 1'b1;
        expect_ev(cyc + 6, 4'b0000, 4'b0001, 4'b0000);
        step(20);

        done = 1'b1;
        while (q.size() > 0) begin
            e = q.pop_front();
            n_vec++;
            n_fail++;
            $display("FAIL missing_event got nothing expected cyc=%0d prs=%b rel=%b", e.cyc, e.press, e.rel);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
